mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between the controller's instruction fetch and its load/store path.
//  Serialises the two requesters with data priority and a starvation guard, and runs the busy handshake.
//  Returns read data/acks to the winner and raises a core-wide stall.
//  Sits between controller/datapath and the memory or cache model.
// PARAMETERS
//  NBITS        8    address width (byte address, matches the controller's PC width)
//  DWIDTH       32   memory data width; instruction = full word, data uses bits [NBITS-1:0]
//  STARVE_LIM   4    consecutive data grants allowed while fetch waits before fetch is forced
//  TIMEOUT      255  max cycles busy may stay high before an access is aborted
// PORTS
//  clock      in   1       system clock, all state on posedge
//  reset      in   1       synchronous, active-low (reset==0 resets)
//  if_req     in   1       fetch request; level, held until if_valid
//  if_addr    in   NBITS   fetch address, stable while if_req
//  if_gnt     out  1       1-cycle pulse: fetch issued to memory this cycle
//  if_valid   out  1       1-cycle pulse: if_rdata valid, fetch complete
//  if_rdata   out  DWIDTH  instruction word
//  d_req      in   1       data request; level, held until d_valid
//  d_we       in   1       1=store, 0=load; stable while d_req
//  d_addr     in   NBITS   data address
//  d_wdata    in   NBITS   store data
//  d_gnt      out  1       1-cycle pulse: data access issued
//  d_valid    out  1       1-cycle pulse: load data valid / store acknowledged
//  d_rdata    out  NBITS   load data (mem_rdata[NBITS-1:0])
//  mem_addr   out  NBITS   memory address
//  mem_wdata  out  DWIDTH  zero-extended d_wdata
//  mem_re     out  1       read strobe, issue cycle only
//  mem_we     out  1       write strobe, issue cycle only
//  mem_rdata  in   DWIDTH  memory read data
//  busy       in   1       memory working; completion = first WAIT cycle with busy==0
//  stall      out  1       (if_req&&!if_valid)||(d_req&&!d_valid), combinational
//  err        out  1       sticky: an access hit TIMEOUT; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE, starve_cnt=0, wdog=0, err=0
//   - all gnt/valid/mem_re/mem_we=0; any in-flight access is abandoned, its data never returned
//  FSM IDLE -> WAIT_IF | WAIT_D -> IDLE.
//  IDLE, arbitration, combinational, same cycle as req:
//   - fetch wins if !d_req, or if (if_req && starve_cnt==STARVE_LIM); otherwise data wins
//   - winner's gnt=1, mem_re/mem_we=1, mem_addr from winner
//   - winner addr, wdata, we and owner latched into regs; go to WAIT_*
//  starve_cnt:
//   - +1 on each data grant while if_req==1
//   - cleared on every fetch grant and whenever if_req==0; saturates at STARVE_LIM
//  WAIT_*:
//   - mem_addr/mem_wdata driven from latched regs; mem_re=mem_we=0
//   - busy==1: wdog+1
//   - busy==0: owner's valid=1 with rdata=mem_rdata (combinational); go to IDLE, wdog=0
//  Latency and throughput:
//   - minimum 2 cycles grant->valid; one access per 2 cycles max
//   - a req still high in the IDLE cycle after valid is treated as a new access
//  Timeout: wdog==TIMEOUT with busy still 1 -> err=1, valid=1 with rdata=0, go to IDLE.
//  Simultaneous if_req and d_req arriving together: data first unless the starvation rule applies.
//  A requester dropping req mid-WAIT is illegal; the access completes and valid still pulses.
//  if_gnt and d_gnt are never 1 in the same cycle; same for if_valid and d_valid.
// STRUCTURE
//  Package mem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} arb_state_t
//   - typedef enum logic {OWN_IF, OWN_D} owner_t
//   - default parameter constants
//  One sub-module arb_starve_counter holds starve_cnt: saturating counter with clear/inc, and a limit flag.
//  FSM, latches and watchdog stay in the top module.
// TESTING
//  1 Lone fetch if_req addr 0x04, busy 0 -> if_gnt+mem_re cycle 0, if_valid cycle 1 with mem_rdata.
//  2 Both req at cycle 0, d_we=1 d_addr 0x10 d_wdata 0xA5 -> d_gnt/mem_we first; if_gnt in IDLE after d_valid.
//  3 d_req held 6 accesses with if_req held -> exactly 4 data grants, then 1 fetch grant, then data resumes.
//  4 busy held 3 cycles after load issue -> d_valid on the 4th WAIT cycle, stall=1 throughout until then.
//  5 reset=0 during WAIT_D -> next cycle IDLE, no d_valid, err=0; later fresh request served normally.
//  6 busy stuck 1 -> after 255 WAIT cycles err=1, valid pulse with rdata 0, err stays 1 until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
// The arbiter serialises instruction fetch and load/store traffic onto a single memory port.
package mem_arb_pkg;

    localparam int NBITS_DEF      = 8;
    localparam int DWIDTH_DEF     = 32;
    localparam int STARVE_LIM_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants taken while fetch is waiting.
// The count saturates at LIMIT, and at_limit is raised while the count sits there.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign at_limit = (count == CW'(LIMIT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and load/store, with data priority and a fetch starvation guard.
// Arbitration happens in IDLE; each WAIT state ends on the first cycle with busy low, or at the watchdog limit.
//
//  state   | meaning
//  IDLE    | port free; arbitrate and issue in the same cycle as the request
//  WAIT_IF | fetch in flight; waiting for busy to drop
//  WAIT_D  | load/store in flight; waiting for busy to drop
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NBITS      = NBITS_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [NBITS-1:0]  if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DWIDTH-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [NBITS-1:0]  d_addr,
    input  logic [NBITS-1:0]  d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [NBITS-1:0]  d_rdata,
    output logic [NBITS-1:0]  mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              busy,
    output logic              stall,
    output logic              err
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_t       state_q, state_d;
    owner_t           owner_q;
    logic [NBITS-1:0] addr_q;
    logic [NBITS-1:0] wdata_q;
    logic             we_q;
    logic [WDW-1:0]   wdog_q;
    logic             err_q;

    logic in_wait, fetch_wins, grant_if, grant_d, timed_out, done, starve_hit;

    // All strobes are gated by reset so nothing is issued or returned while it is held.
    assign in_wait    = (state_q != IDLE);
    assign fetch_wins = if_req && (!d_req || starve_hit);
    assign grant_if   = reset && !in_wait && fetch_wins;
    assign grant_d    = reset && !in_wait && d_req && !fetch_wins;
    assign timed_out  = in_wait && busy && (wdog_q == WDW'(TIMEOUT));
    assign done       = reset && in_wait && (!busy || timed_out);

    assign stall = (if_req && !if_valid) || (d_req && !d_valid);
    assign err   = err_q;

    arb_starve_counter #(
        .LIMIT (STARVE_LIM)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .clr      (grant_if || !if_req),
        .inc      (grant_d && if_req),
        .at_limit (starve_hit)
    );

    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_addr  = addr_q;
        mem_wdata = we_q ? DWIDTH'(wdata_q) : '0;
        if (grant_if) begin
            if_gnt    = 1'b1;
            mem_re    = 1'b1;
            mem_addr  = if_addr;
            mem_wdata = '0;
            state_d   = WAIT_IF;
        end else if (grant_d) begin
            d_gnt     = 1'b1;
            mem_re    = !d_we;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = DWIDTH'(d_wdata);
            state_d   = WAIT_D;
        end else if (done) begin
            if (owner_q == OWN_IF) begin
                if_valid = 1'b1;
                if_rdata = timed_out ? '0 : mem_rdata;
            end else begin
                d_valid = 1'b1;
                d_rdata = timed_out ? '0 : mem_rdata[NBITS-1:0];
            end
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_if) begin
                owner_q <= OWN_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
            end else if (grant_d) begin
                owner_q <= OWN_D;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                we_q    <= d_we;
            end
            if (done) begin
                wdog_q <= '0;
            end else if (in_wait && busy) begin
                wdog_q <= wdog_q + WDW'(1);
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// The model drives inputs on the falling edge and checks outputs shortly afterwards.
module tb_mem_port_arbiter;

    localparam int NB = 8;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [NB-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [NB-1:0] d_addr = '0;
    logic [NB-1:0] d_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy = 1'b0;

    logic          if_gnt, if_valid, d_gnt, d_valid, mem_re, mem_we, stall, err;
    logic [DW-1:0] if_rdata, mem_wdata;
    logic [NB-1:0] d_rdata, mem_addr;

    mem_port_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .stall     (stall),
        .err       (err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: memory contents, in-flight access and fairness streak.
    logic [DW-1:0] mem [256];
    bit outstanding = 0;
    bit own_if = 0;
    bit err_exp = 0;
    int streak = 0;
    int busy_cnt = 0;
    bit last_ifv = 0;
    bit last_dv = 0;

    // Observed DUT values from the latest cycle, for the directed scenarios.
    logic          obs_ifg, obs_dg, obs_ifv, obs_dv, obs_re, obs_we, obs_stall, obs_err;
    logic [DW-1:0] obs_ifrd;
    logic [NB-1:0] obs_drd;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit g_if, g_d, any, tmo, v_exp, v_if, v_d;
        logic [DW-1:0] rd;
        mem_rdata = outstanding ? mem[own_if ? if_addr : d_addr] : DW'($urandom);
        #1;
        any   = reset && !outstanding && (if_req || d_req);
        g_if  = any && if_req && (!d_req || streak == SL);
        g_d   = any && !g_if;
        tmo   = outstanding && busy && (busy_cnt == TO);
        v_exp = reset && outstanding && (!busy || tmo);
        v_if  = v_exp && own_if;
        v_d   = v_exp && !own_if;
        rd    = tmo ? '0 : mem_rdata;

        obs_ifg = if_gnt;   obs_dg = d_gnt;     obs_ifv = if_valid; obs_dv = d_valid;
        obs_re  = mem_re;   obs_we = mem_we;    obs_stall = stall;  obs_err = err;
        obs_ifrd = if_rdata; obs_drd = d_rdata;

        chk_eq("if_gnt", if_gnt, g_if);
        chk_eq("d_gnt", d_gnt, g_d);
        chk_eq("mem_re", mem_re, g_if || (g_d && !d_we));
        chk_eq("mem_we", mem_we, g_d && d_we);
        chk_eq("if_valid", if_valid, v_if);
        chk_eq("d_valid", d_valid, v_d);
        chk_eq("stall", stall, (if_req && !v_if) || (d_req && !v_d));
        chk_eq("err", err, err_exp);
        if (g_if) chk_eq("mem_addr_if", mem_addr, if_addr);
        if (g_d) begin
            chk_eq("mem_addr_d", mem_addr, d_addr);
            if (d_we) chk_eq("mem_wdata", mem_wdata, {24'b0, d_wdata});
        end
        if (outstanding && reset) chk_eq("mem_addr_wait", mem_addr, own_if ? if_addr : d_addr);
        if (v_if) chk_eq("if_rdata", if_rdata, rd);
        if (v_d) chk_eq("d_rdata", d_rdata, rd[7:0]);

        last_ifv = v_if;
        last_dv  = v_d;
        if (!reset) begin
            outstanding = 0;
            streak = 0;
            err_exp = 0;
            busy_cnt = 0;
        end else begin
            if (g_if || !if_req) streak = 0;
            else if (g_d && streak < SL) streak++;
            if (g_if || g_d) begin
                outstanding = 1;
                own_if = g_if;
                busy_cnt = 0;
                if (g_d && d_we) mem[d_addr] = {24'b0, d_wdata};
            end else if (v_exp) begin
                outstanding = 0;
                if (tmo) err_exp = 1;
            end else if (outstanding && busy) begin
                busy_cnt++;
            end
        end
        @(negedge clock);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        busy = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        logic [6:0] seq;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        @(negedge clock);
        reset_dut();

        // Lone fetch, zero wait states.
        if_req = 1; if_addr = 8'h04; busy = 0;
        step();
        chk_eq("t1_if_gnt", obs_ifg, 1);
        chk_eq("t1_mem_re", obs_re, 1);
        step();
        chk_eq("t1_if_valid", obs_ifv, 1);
        chk_eq("t1_rdata", obs_ifrd, mem[4]);
        if_req = 0;
        step();

        // Simultaneous requests: store goes first, fetch follows.
        reset_dut();
        if_req = 1; if_addr = 8'h20;
        d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 8'hA5;
        step();
        chk_eq("t2_d_gnt", obs_dg, 1);
        chk_eq("t2_if_gnt_held", obs_ifg, 0);
        chk_eq("t2_mem_we", obs_we, 1);
        step();
        chk_eq("t2_d_valid", obs_dv, 1);
        d_req = 0;
        step();
        chk_eq("t2_if_gnt", obs_ifg, 1);
        step();
        chk_eq("t2_if_valid", obs_ifv, 1);
        if_req = 0;
        d_req = 1; d_we = 0; d_addr = 8'h10;
        step();
        step();
        chk_eq("t2_readback", obs_drd, 8'hA5);
        d_req = 0;
        step();

        // Starvation guard with both requesters always pending.
        reset_dut();
        if_req = 1; if_addr = 8'h30;
        d_req = 1; d_we = 0; d_addr = 8'h31;
        seq = '0;
        n = 0;
        for (int c = 0; c < 60 && n < 7; c++) begin
            step();
            if (obs_ifg || obs_dg) begin
                seq = {seq[5:0], obs_dg};
                n++;
            end
            if (last_ifv) if_addr = NB'($urandom);
            if (last_dv) d_addr = NB'($urandom);
        end
        chk_eq("t3_grants", n, 7);
        chk_eq("t3_order", seq, 7'b1111011);
        if_req = 0; d_req = 0;
        repeat (3) step();

        // Three busy cycles stretch a load to the fourth wait cycle.
        reset_dut();
        d_req = 1; d_we = 0; d_addr = 8'h33; busy = 0;
        step();
        chk_eq("t4_d_gnt", obs_dg, 1);
        busy = 1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) busy = 0;
            step();
            n++;
            if (obs_dv) break;
            chk_eq("t4_stall", obs_stall, 1);
        end
        chk_eq("t4_latency", n, 4);
        d_req = 0; busy = 0;
        step();

        // Reset during a data wait abandons the access.
        reset_dut();
        d_req = 1; d_we = 0; d_addr = 8'h44;
        step();
        busy = 1;
        step();
        reset = 0; busy = 0;
        step();
        chk_eq("t5_no_valid", obs_dv, 0);
        chk_eq("t5_err", obs_err, 0);
        reset = 1; d_req = 0;
        step();
        d_req = 1; d_addr = 8'h45;
        step();
        chk_eq("t5_d_gnt", obs_dg, 1);
        step();
        chk_eq("t5_d_valid", obs_dv, 1);
        chk_eq("t5_rdata", obs_drd, mem[8'h45][7:0]);
        d_req = 0;
        step();

        // Busy stuck high trips the watchdog.
        reset_dut();
        if_req = 1; if_addr = 8'h50; busy = 1;
        step();
        n = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            n++;
            if (obs_ifv) break;
        end
        chk_eq("t6_waits", n, 256);
        chk_eq("t6_rdata", obs_ifrd, 0);
        if_req = 0; busy = 0;
        step();
        chk_eq("t6_err", obs_err, 1);
        repeat (3) step();
        chk_eq("t6_err_hold", obs_err, 1);
        reset_dut();
        step();
        chk_eq("t6_err_clr", obs_err, 0);

        // Randomized traffic; each requester holds its attributes until its valid.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            busy = ($urandom_range(3) == 0);
            if (!if_req || last_ifv) begin
                if_req = ($urandom_range(2) != 0);
                if_addr = NB'($urandom);
            end
            if (!d_req || last_dv) begin
                d_req = ($urandom_range(2) != 0);
                d_we = $urandom_range(1);
                d_addr = NB'($urandom);
                d_wdata = NB'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
